// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : param_updown_counter
// Description : Parametrised up/down event/timebase counter with wrap or
//               saturate at the modulus bounds, synchronous clear and load,
//               registered overflow/underflow pulses, sticky status flags and
//               a combinational terminal-count flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      counter width in bits (2..32)
//   MODULUS    count range 0..MODULUS-1, 2 <= MODULUS <= 2^WIDTH
// Ports
//   clk        in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   EN         in   count enable
//   CLR        in   synchronous clear (highest priority)
//   LOAD       in   synchronous load of load_value (clamped to MODULUS-1)
//   load_value in   value taken when LOAD=1
//   UP         in   1 = increment, 0 = decrement
//   MODE       in   0 = wrap at modulus, 1 = saturate at bounds
//   FLAG_CLR   in   synchronous clear of the sticky flags
//   counter    out  current count (registered)
//   OV / UV    out  one-cycle overflow / underflow pulses (registered)
//   TC         out  terminal count in the current direction (combinational)
//   OV_sticky  out  latched overflow status
//   UV_sticky  out  latched underflow status
// ============================================================================
module param_updown_counter #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 256
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             EN,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] load_value,
    input  logic             UP,
    input  logic             MODE,
    input  logic             FLAG_CLR,
    output logic [WIDTH-1:0] counter,
    output logic             OV,
    output logic             UV,
    output logic             TC,
    output logic             OV_sticky,
    output logic             UV_sticky
);

    // Upper bound held in WIDTH bits; with MODULUS = 2^WIDTH this is all ones,
    // so the wrap path coincides with natural binary rollover.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ov_q, ov_d;
    logic             uv_q, uv_d;
    logic             ovs_q, ovs_d;
    logic             uvs_q, uvs_d;

    always_comb begin
        cnt_d = cnt_q;
        ov_d  = 1'b0;
        uv_d  = 1'b0;

        if (CLR) begin
            cnt_d = '0;
        end else if (LOAD) begin
            // Out-of-range loads clamp so the count never leaves 0..MODULUS-1.
            cnt_d = (load_value > MAX_VAL) ? MAX_VAL : load_value;
        end else if (EN) begin
            if (UP) begin
                if (cnt_q >= MAX_VAL) begin
                    ov_d  = 1'b1;
                    cnt_d = MODE ? MAX_VAL : '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    uv_d  = 1'b1;
                    cnt_d = MODE ? '0 : MAX_VAL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end

        // A set event on the same edge as FLAG_CLR wins.
        ovs_d = ov_d | (ovs_q & ~FLAG_CLR);
        uvs_d = uv_d | (uvs_q & ~FLAG_CLR);
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
            ov_q  <= 1'b0;
            uv_q  <= 1'b0;
            ovs_q <= 1'b0;
            uvs_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ov_q  <= ov_d;
            uv_q  <= uv_d;
            ovs_q <= ovs_d;
            uvs_q <= uvs_d;
        end
    end

    assign counter   = cnt_q;
    assign OV        = ov_q;
    assign UV        = uv_q;
    assign OV_sticky = ovs_q;
    assign UV_sticky = uvs_q;
    assign TC        = (UP && (cnt_q == MAX_VAL)) || (!UP && (cnt_q == '0));

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_updown_counter
// Description : Directed self-checking bench for param_updown_counter, with a
//               default 8-bit/256 instance and a 4-bit/modulus-10 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_updown_counter;

    logic clk = 1'b0;
    logic Reset;

    // Default instance (WIDTH=8, MODULUS=256)
    logic       en8, clr8, load8, up8, mode8, fclr8;
    logic [7:0] lv8, cnt8;
    logic       ov8, uv8, tc8, ovs8, uvs8;

    // Modulus-10 instance (WIDTH=4)
    logic       en10, clr10, load10, up10, mode10, fclr10;
    logic [3:0] lv10, cnt10;
    logic       ov10, uv10, tc10, ovs10, uvs10;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    param_updown_counter u_d8 (
        .clk(clk), .Reset(Reset), .EN(en8), .CLR(clr8), .LOAD(load8),
        .load_value(lv8), .UP(up8), .MODE(mode8), .FLAG_CLR(fclr8),
        .counter(cnt8), .OV(ov8), .UV(uv8), .TC(tc8),
        .OV_sticky(ovs8), .UV_sticky(uvs8)
    );

    param_updown_counter #(.WIDTH(4), .MODULUS(10)) u_d10 (
        .clk(clk), .Reset(Reset), .EN(en10), .CLR(clr10), .LOAD(load10),
        .load_value(lv10), .UP(up10), .MODE(mode10), .FLAG_CLR(fclr10),
        .counter(cnt10), .OV(ov10), .UV(uv10), .TC(tc10),
        .OV_sticky(ovs10), .UV_sticky(uvs10)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        en8 = 1'b1; clr8 = 1'b0; load8 = 1'b0; up8 = 1'b1; mode8 = 1'b0; fclr8 = 1'b0; lv8 = '0;
        en10 = 1'b0; clr10 = 1'b0; load10 = 1'b0; up10 = 1'b1; mode10 = 1'b0; fclr10 = 1'b0; lv10 = '0;

        // ---- Reset state, including an edge (t=5) with Reset low ----
        #1;
        chk("rst_cnt", 32'(cnt8), 32'h0);
        chk("rst_ov", 32'(ov8), 32'h0);
        chk("rst_ovs", 32'(ovs8), 32'h0);
        #6;
        chk("rst_hold_cnt", 32'(cnt8), 32'h0);
        #7;
        Reset = 1'b1;               // t=14

        // ---- Full up-count with wrap at 255 ----
        for (int i = 1; i <= 255; i++) begin
            tick();
            chk("up_cnt", 32'(cnt8), 32'(i));
            chk("up_ov", 32'(ov8), 32'h0);
        end
        chk("tc_at_255", 32'(tc8), 32'h1);
        tick();
        chk("wrap_cnt", 32'(cnt8), 32'h0);
        chk("wrap_ov", 32'(ov8), 32'h1);
        chk("wrap_ovs", 32'(ovs8), 32'h1);
        tick();
        chk("post_wrap_cnt", 32'(cnt8), 32'h1);
        chk("post_wrap_ov", 32'(ov8), 32'h0);
        chk("post_wrap_ovs", 32'(ovs8), 32'h1);

        // ---- Saturate mode: load 254 then three enabled edges ----
        mode8 = 1'b1; load8 = 1'b1; lv8 = 8'd254;
        tick();
        chk("sat_load_cnt", 32'(cnt8), 32'd254);
        chk("sat_load_ov", 32'(ov8), 32'h0);
        load8 = 1'b0;
        tick();
        chk("sat1_cnt", 32'(cnt8), 32'd255);
        chk("sat1_ov", 32'(ov8), 32'h0);
        tick();
        chk("sat2_cnt", 32'(cnt8), 32'd255);
        chk("sat2_ov", 32'(ov8), 32'h1);
        tick();
        chk("sat3_cnt", 32'(cnt8), 32'd255);
        chk("sat3_ov", 32'(ov8), 32'h1);

        // ---- OV event with FLAG_CLR on the same edge: set wins ----
        fclr8 = 1'b1;
        tick();
        chk("setwin_ov", 32'(ov8), 32'h1);
        chk("setwin_ovs", 32'(ovs8), 32'h1);
        en8 = 1'b0;
        tick();
        chk("fclr_ov", 32'(ov8), 32'h0);
        chk("fclr_ovs", 32'(ovs8), 32'h0);
        chk("hold_cnt", 32'(cnt8), 32'd255);
        fclr8 = 1'b0;

        // ---- Down count from 0 in saturate mode holds and pulses UV ----
        up8 = 1'b0; en8 = 1'b1;
        clr8 = 1'b1;
        tick();
        clr8 = 1'b0;
        chk("clr_cnt", 32'(cnt8), 32'h0);
        tick();
        chk("satdn_cnt", 32'(cnt8), 32'h0);
        chk("satdn_uv", 32'(uv8), 32'h1);
        chk("satdn_uvs", 32'(uvs8), 32'h1);

        // ---- Mid-count asynchronous reset at 0x37 ----
        en8 = 1'b0; up8 = 1'b1; mode8 = 1'b0;
        load8 = 1'b1; lv8 = 8'h37;
        tick();
        load8 = 1'b0;
        chk("pre_rst_cnt", 32'(cnt8), 32'h37);
        chk("pre_rst_uvs", 32'(uvs8), 32'h1);
        #2;
        Reset = 1'b0;
        #1;
        chk("arst_cnt", 32'(cnt8), 32'h0);
        chk("arst_uvs", 32'(uvs8), 32'h0);
        chk("arst_uv", 32'(uv8), 32'h0);
        en8 = 1'b1;
        tick();
        chk("arst_hold_cnt", 32'(cnt8), 32'h0);
        #2;
        Reset = 1'b1;
        tick();
        chk("resume_cnt", 32'(cnt8), 32'h1);
        en8 = 1'b0;

        // ---- Modulus 10: down through 0 wraps to 9 ----
        up10 = 1'b0; load10 = 1'b1; lv10 = 4'd2;
        tick();
        load10 = 1'b0; en10 = 1'b1;
        chk("m10_load2", 32'(cnt10), 32'd2);
        tick();
        chk("m10_dn1", 32'(cnt10), 32'd1);
        chk("m10_tc1", 32'(tc10), 32'h0);
        tick();
        chk("m10_dn0", 32'(cnt10), 32'd0);
        chk("m10_tc0", 32'(tc10), 32'h1);
        chk("m10_uv0", 32'(uv10), 32'h0);
        tick();
        chk("m10_wrap", 32'(cnt10), 32'd9);
        chk("m10_wrap_uv", 32'(uv10), 32'h1);
        chk("m10_wrap_uvs", 32'(uvs10), 32'h1);
        chk("m10_wrap_tc", 32'(tc10), 32'h0);
        tick();
        chk("m10_dn8", 32'(cnt10), 32'd8);
        chk("m10_dn8_uv", 32'(uv10), 32'h0);

        // ---- Modulus 10: load clamp, then CLR beats LOAD ----
        en10 = 1'b0; load10 = 1'b1; lv10 = 4'd15;
        tick();
        chk("m10_clamp", 32'(cnt10), 32'd9);
        clr10 = 1'b1; lv10 = 4'd5;
        tick();
        chk("m10_clr_pri", 32'(cnt10), 32'd0);
        clr10 = 1'b0;

        // ---- Modulus 10: up wrap from 9 to 0 with OV ----
        lv10 = 4'd9;
        tick();
        chk("m10_load9", 32'(cnt10), 32'd9);
        load10 = 1'b0; up10 = 1'b1; en10 = 1'b1;
        #1;
        chk("m10_tc_up", 32'(tc10), 32'h1);
        tick();
        chk("m10_upwrap", 32'(cnt10), 32'd0);
        chk("m10_upwrap_ov", 32'(ov10), 32'h1);
        chk("m10_upwrap_uv", 32'(uv10), 32'h0);
        en10 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised successor to the team's 8-bit enable/clear counter.
- Adds width and modulus parameters, up/down direction, synchronous load, and a wrap or saturate mode.
- Adds registered overflow/underflow pulses with sticky status and a terminal-count flag.
- Serves as the general event/timebase counter feeding downstream datapath blocks.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MODULUS, 256, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2^WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-low reset
- EN  input  1  count enable
- CLR  input  1  synchronous clear to 0
- LOAD  input  1  synchronous load of load_value
- load_value  input  WIDTH  value taken when LOAD=1
- UP  input  1  direction: 1 = increment, 0 = decrement
- MODE  input  1  0 = wrap at modulus, 1 = saturate at 0 / MODULUS-1
- FLAG_CLR  input  1  synchronous clear of OV_sticky and UV_sticky
- counter  output  WIDTH  current count (registered)
- OV  output  1  one-cycle registered overflow pulse
- UV  output  1  one-cycle registered underflow pulse
- TC  output  1  combinational terminal count: (UP && counter==MODULUS-1) || (!UP && counter==0)
- OV_sticky  output  1  latched overflow status
- UV_sticky  output  1  latched underflow status

Behaviour:
- Reset low (asynchronous, any time, including mid-count):
  - counter, OV, UV, OV_sticky, UV_sticky all go to 0 immediately.
  - All of them hold 0 while Reset is low.
  - First update occurs on the first rising clk edge after Reset returns high.
- Priority per edge: CLR > LOAD > EN. With EN=0 and no CLR/LOAD, counter holds.
- CLR=1:
  - counter <= 0.
  - OV/UV <= 0.
  - Sticky flags are unaffected.
- LOAD=1:
  - counter <= load_value if load_value <= MODULUS-1, else counter <= MODULUS-1 (clamp).
  - OV/UV <= 0.
- EN=1, UP=1:
  - If counter < MODULUS-1: counter+1.
  - At MODULUS-1 with MODE=0: counter <= 0, OV <= 1.
  - At MODULUS-1 with MODE=1: counter holds MODULUS-1, OV <= 1.
- EN=1, UP=0:
  - If counter > 0: counter-1.
  - At 0 with MODE=0: counter <= MODULUS-1, UV <= 1.
  - At 0 with MODE=1: counter holds 0, UV <= 1.
- OV and UV latency:
  - Each is high for exactly one cycle, in the same cycle the wrapped/held value is visible on counter.
  - Each is 0 on every edge without an overflow/underflow event.
  - OV and UV are never high together.
- Sticky flags:
  - OV_sticky sets on the edge where OV is set; UV_sticky likewise with UV.
  - Both clear on an edge with FLAG_CLR=1.
  - A simultaneous set event and FLAG_CLR=1: set wins, flag stays 1.
- Direction change: UP may change any cycle and takes effect on the next edge. No pipeline, single-cycle latency.
- MODE change: takes effect on the next edge. A counter value already at a bound is not altered by a MODE change alone.
- Arithmetic:
  - Internal compare against MODULUS-1 uses WIDTH bits.
  - When MODULUS = 2^WIDTH, natural wrap equals modular wrap.
  - Non-power-of-two MODULUS must never produce values >= MODULUS.

Test Plan:
- Defaults, Reset low 14 time units then high, EN=1, UP=1, MODE=0 -> counter 0,1,...,255,0. OV=1 only in the cycle counter=0 after 255. OV_sticky=1 thereafter.
- MODULUS=10, UP=0, EN=1 from counter=2 -> 1,0,9,8. UV pulses with counter=9. TC=1 while counter=0.
- MODE=1, UP=1, LOAD load_value=254, then EN=1 for 4 cycles -> counter 254,255,255,255. OV pulses on each blocked edge (2 pulses).
- MODULUS=10, LOAD=1 load_value=15 -> counter=9. Same cycle CLR=1 with LOAD=1 -> counter=0.
- OV event and FLAG_CLR=1 on the same edge -> OV_sticky stays 1. FLAG_CLR alone on the next edge -> OV_sticky=0.
- Reset pulsed low mid-count at counter=0x37 between clock edges -> counter and all flags 0 immediately. Counting resumes at 1 on the first edge after release.
